// File: rtl/uart_pkg.sv
// uart_pkg: line-state encoding and bit-timing helper shared by the UART transmitter and receiver
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    function automatic int calc_t_count(input int frequency, input int baudrate);
        return frequency / baudrate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: per-bit clock divider, restarted by clear, ticking on the last clock of each bit period
module uart_baud_gen #(
    parameter int T_COUNT = 108
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int W = $clog2(T_COUNT);
    localparam logic [W-1:0] LAST = W'(T_COUNT - 1);

    logic [W-1:0] count;

    assign bit_tick = count == LAST;

    // count 0..T_COUNT-1 while enabled, wrap on the tick, restart on clear
    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (enable)
            count <= bit_tick ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-bit LSB-first serial transmitter with valid/ready input; optional parity bit under UART_TX_PARITY_EN
module uart_tx
    import uart_pkg::*;
#(
    parameter int FREQUENCY  = 100_000_000,
    parameter int BAUDRATE   = 921_600,
    parameter int T_COUNT    = calc_t_count(FREQUENCY, BAUDRATE),
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_TX,
    output logic       o_busy,
    output logic       o_done
);

    if (T_COUNT < 2) begin : g_bad_t_count
        $error("uart_tx: T_COUNT must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    localparam logic LAST_STOP = 1'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
    localparam uart_state_t AFTER_DATA = PARITY;
    logic par;
`else
    localparam uart_state_t AFTER_DATA = STOP;
`endif

    uart_state_t state, next_state;
    logic [7:0]  shreg;
    logic [2:0]  bit_idx;
    logic        stop_idx;
    logic        bit_tick;
    logic        accept;
    logic        tx_next;
    logic        done_next;

    assign o_ready = state == IDLE;
    assign o_busy  = state != IDLE;
    assign accept  = i_valid && o_ready;

    uart_baud_gen #(.T_COUNT(T_COUNT)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .enable   (o_busy),
        .bit_tick (bit_tick)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // frame sequencing: every state lasts whole bit periods and moves on the baud tick
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? START : IDLE;
            START:   next_state = bit_tick ? DATA : START;
            DATA:    next_state = (bit_tick && bit_idx == 3'd7) ? AFTER_DATA : DATA;
            PARITY:  next_state = bit_tick ? STOP : PARITY;
            STOP:    next_state = (bit_tick && stop_idx == LAST_STOP) ? IDLE : STOP;
            default: next_state = IDLE;
        endcase
    end

    // line level for the coming state; a data tick exposes the next bit before the shift lands
    always_comb begin
        tx_next = 1'b1;
        case (next_state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = (state == DATA && bit_tick) ? shreg[1] : shreg[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = par;
`endif
            default: tx_next = 1'b1;
        endcase
        done_next = state == STOP && next_state == IDLE;
    end

    // byte capture on accept, then shift and count once per bit period
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else if (accept) begin
            shreg    <= i_data;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= ^i_data ^ (PARITY_ODD != 0);
`endif
        end else if (bit_tick) begin
            if (state == DATA) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 3'd1;
            end
            if (state == STOP)
                stop_idx <= ~stop_idx;
        end
    end

    // registered line and end-of-frame pulse so the pins never glitch
    always_ff @(posedge clk) begin
        if (reset) begin
            o_TX   <= 1'b1;
            o_done <= 1'b0;
        end else begin
            o_TX   <= tx_next;
            o_done <= done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: vector table plus random frames for uart_tx, checked every clock against a bit-list frame model
module tb_uart_tx;

    localparam int T     = 10;
    localparam int STOPS = 1;
    localparam bit PODD  = 1'b0;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int NBITS = 1 + 8 + PBITS + STOPS;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_valid = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_ready, o_TX, o_busy, o_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .FREQUENCY  (1_000_000),
        .BAUDRATE   (100_000),
        .STOP_BITS  (STOPS),
        .PARITY_ODD (0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_TX    (o_TX),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    typedef struct {
        logic [7:0] data;
        logic       par_even;
        bit         b2b;
        bit         noise;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input logic par, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (PBITS == 1 && idx == 9) return par;
        return 1'b1;
    endfunction

    task automatic idle_gap(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_tx", o_TX, 1'b1);
            chk("idle_done", o_done, 1'b0);
            chk("idle_ready", o_ready, 1'b1);
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input logic par, input bit noise);
        chk("ready_before_send", o_ready, 1'b1);
        i_data  = d;
        i_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < NBITS * T; k++) begin
            @(negedge clk);
            chk("tx_bit", o_TX, exp_bit(d, par, k / T));
            chk("busy_high", o_busy, 1'b1);
            chk("ready_low", o_ready, 1'b0);
            chk("done_low", o_done, 1'b0);
            i_valid = (noise && k < NBITS * T - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_data  = noise ? 8'($urandom) : d;
        end
        @(negedge clk);
        chk("done_pulse", o_done, 1'b1);
        chk("ready_in_done", o_ready, 1'b1);
        chk("tx_high_in_done", o_TX, 1'b1);
        chk("busy_low_in_done", o_busy, 1'b0);
    endtask

    initial begin
        vecs = '{
            '{8'hA5, 1'b0, 1'b0, 1'b0},
            '{8'h00, 1'b0, 1'b0, 1'b0},
            '{8'hFF, 1'b0, 1'b1, 1'b0},
            '{8'h81, 1'b0, 1'b0, 1'b1},
            '{8'h07, 1'b1, 1'b0, 1'b0},
            '{8'h3C, 1'b0, 1'b1, 1'b1},
            '{8'h01, 1'b1, 1'b0, 1'b0},
            '{8'h80, 1'b1, 1'b1, 1'b0},
            '{8'hFE, 1'b1, 1'b0, 1'b1},
            '{8'h55, 1'b0, 1'b0, 1'b0}
        };

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", o_TX, 1'b1);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        reset = 1'b0;
        idle_gap(20);

        for (int i = 0; i < 10; i++) begin
            if (!vecs[i].b2b) idle_gap(1 + i % 3);
            run_frame(vecs[i].data, vecs[i].par_even ^ PODD, vecs[i].noise);
        end

        idle_gap(2);
        i_data  = 8'h81;
        i_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 5 * T + 4; k++) begin
            @(negedge clk);
            chk("abort_tx_bit", o_TX, exp_bit(8'h81, 1'b0, k / T));
            i_valid = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_tx_high", o_TX, 1'b1);
        chk("abort_ready", o_ready, 1'b1);
        chk("abort_busy", o_busy, 1'b0);
        chk("abort_done", o_done, 1'b0);
        reset = 1'b0;
        idle_gap(NBITS * T + 5);
        run_frame(8'h55, 1'b0 ^ PODD, 1'b0);

        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            bit b2b, noise;
            d     = 8'($urandom);
            b2b   = 1'($urandom_range(0, 1));
            noise = 1'($urandom_range(0, 1));
            if (!b2b) idle_gap($urandom_range(1, 5));
            run_frame(d, ^d ^ PODD, noise);
        end
        idle_gap(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
